typewriter_out: RTL
===================

# typewriter_out

Output side of the typewriter path: accepts 6-bit FIO-DEC codes from the CPU typewriter-output instruction and decodes them into 7-bit ASCII with a cursor position. Tracks the shift state (upper/lower case) and handles the control codes. Buffers results in a small FIFO that drains to the on-screen teletype renderer over a valid/ready handshake. It mirrors the keyboard encoder, which produces the same FIO-DEC codes on the input side.

## Interface
Parameters:
- COLS, 64, teletype columns; power of two not required
- ROWS, 32, teletype rows
- DEPTH, 8, FIFO entries; power of two

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- tyo_strobe  in  1  CPU output request; a rising edge starts a transfer
- tyo_char  in  6  FIO-DEC code, valid while tyo_strobe is high
- tyo_done  out  1  one-cycle pulse when the code has been consumed
- term_valid  out  1  FIFO head valid
- term_ready  in  1  renderer accepts head
- term_char  out  7  ASCII character; 0 when term_scroll=1
- term_x  out  6  column of term_char
- term_y  out  5  row of term_char
- term_scroll  out  1  entry is a scroll-up command, not a character
- upper_case  out  1  current shift state

## Operation
- Edge detect: tyo_strobe is registered. A rising edge latches tyo_char and sets pending.
  - An edge while pending=1 is dropped. The CPU never issues one, since it waits for tyo_done.
- When pending=1, one decode/commit happens per cycle. The commit is stalled while the FIFO cannot take all entries the code produces (at most 2).
- Decode, using cursor (cx, cy), reset (0,0):
  - o72: upper_case←0, no entry.
  - o74: upper_case←1, no entry.
  - o77 (CR): cx←0, then newline.
  - o75 (BS): cx←max(cx−1, 0), no entry.
  - o36 (TAB): cx←(cx|7)+1. If the result ≥COLS, cx←0 and newline. No entry.
  - o56: entry '|' at (cx,cy), cx unchanged (overstrike).
  - o00: entry ' ', then advance.
  - printable: entry fiodec_to_ascii(code, upper_case) at (cx,cy), then advance.
  - Letters: a–i o61–o71, j–r o41–o51, s–z o22–o31. Lower case gives a–z, upper case gives A–Z.
  - Digits 1–9 are o01–o11 and 0 is o20. Their upper-case forms are " ' ~ # ! & < > ^ and ` for 0.
  - Punctuation, lower/upper: o33 ,/= ; o21 //? ; o57 (/[ ; o55 )/] ; o73 ./* ; o54 -/+ ; o40 ./_ .
  - Any other code: no entry and no cursor change, but still acknowledged.
- Advance: cx+1. At COLS it wraps to cx←0 and triggers a newline.
- Newline: if cy<ROWS−1 then cy+1. Otherwise cy stays and a scroll entry {term_scroll=1} is pushed after any character entry of the same code.
- FIFO:
  - First-word-fall-through; head drives term_*.
  - Pop when term_valid & term_ready.
  - Push uses the count registered at the start of the cycle. A pop in the same cycle does not free space for that cycle's push.
  - Pointers wrap modulo DEPTH.

## Timing
- The edge is seen in cycle k (strobe_q=0, tyo_strobe=1), and pending=1 from k+1.
- With the FIFO not full, entries are written at the end of k+1, tyo_done=1 during k+2, and term_valid=1 during k+2.
- FIFO full: commit stalls with pending held. tyo_done follows 1 cycle after the commit.
- term_ready low: the head is held stable; term_* must not change while term_valid=1 and term_ready=0.
- Reset, including mid-transfer:
  - pending=0, tyo_done=0, FIFO empty, term_valid=0.
  - term_char, term_x, term_y and term_scroll = 0.
  - upper_case=0, cursor (0,0).
  - strobe_q=0, so a tyo_strobe held high through reset release counts as an edge.

## Structure
- Package fiodec_pkg:
  - code constants FD_SPACE, FD_TAB, FD_LOWER, FD_UPPER, FD_BS, FD_CR, FD_OVERSTRIKE
  - function fiodec_to_ascii(code, upper) returning {valid, ascii}
  - entry struct {scroll, char, x, y}
  - These are shared with the keyboard encoder tables.
- Sub-module fiodec_fifo: synchronous FWFT FIFO of entry structs with DEPTH, push/pop, full/empty/count.
- Top holds the edge detect, pending, case/cursor registers and commit logic.

## Test plan
- Reset, then tyo_char=o61 edge → entry 'a' at (0,0); tyo_done pulse exactly 2 cycles after the edge.
- o74, o61, o72, o61 → entries 'A' (0,0), 'a' (1,0); upper_case reads 1 then 0; exactly 4 tyo_done pulses.
- Cursor at (63,31), print o02 → entry '2' (63,31), then a scroll entry; cursor (0,31).
- o36 at cx=3 → cx=8, no entry. Then o75 three times at cx=1 → cx=0, no entries.
- term_ready=0 with 9 codes issued → 8 entries held, and the 9th tyo_done is withheld until one pop occurs, after which it completes.
- Reset asserted while pending and the FIFO holds 3 entries → all outputs 0 next cycle; the next edge produces an entry at (0,0).

Source files
------------

// File: rtl/fiodec_pkg.sv
// FIO-DEC code constants, the teletype entry record and the FIO-DEC to ASCII table.
// Shared between the typewriter output path and the keyboard encoder.
package fiodec_pkg;

    localparam logic [5:0] FD_SPACE      = 6'o00;
    localparam logic [5:0] FD_TAB        = 6'o36;
    localparam logic [5:0] FD_LOWER      = 6'o72;
    localparam logic [5:0] FD_UPPER      = 6'o74;
    localparam logic [5:0] FD_BS         = 6'o75;
    localparam logic [5:0] FD_CR         = 6'o77;
    localparam logic [5:0] FD_OVERSTRIKE = 6'o56;

    typedef struct packed {
        logic       scroll;
        logic [6:0] ch;
        logic [5:0] x;
        logic [4:0] y;
    } entry_t;

    // Returns {valid, ascii}; valid=0 for codes with no printable glyph.
    function automatic logic [7:0] fiodec_to_ascii(input logic [5:0] code, input logic upper);
        logic [6:0] a;
        logic       v;
        v = 1'b1;
        a = '0;
        if (code >= 6'o61 && code <= 6'o71) begin
            a = 7'h61 + 7'(code - 6'o61);
            if (upper) a = a - 7'h20;
        end else if (code >= 6'o41 && code <= 6'o51) begin
            a = 7'h6A + 7'(code - 6'o41);
            if (upper) a = a - 7'h20;
        end else if (code >= 6'o22 && code <= 6'o31) begin
            a = 7'h73 + 7'(code - 6'o22);
            if (upper) a = a - 7'h20;
        end else begin
            case (code)
                6'o00: a = 7'h20;
                6'o01: a = upper ? 7'h22 : 7'h31;
                6'o02: a = upper ? 7'h27 : 7'h32;
                6'o03: a = upper ? 7'h7E : 7'h33;
                6'o04: a = upper ? 7'h23 : 7'h34;
                6'o05: a = upper ? 7'h21 : 7'h35;
                6'o06: a = upper ? 7'h26 : 7'h36;
                6'o07: a = upper ? 7'h3C : 7'h37;
                6'o10: a = upper ? 7'h3E : 7'h38;
                6'o11: a = upper ? 7'h5E : 7'h39;
                6'o20: a = upper ? 7'h60 : 7'h30;
                6'o33: a = upper ? 7'h3D : 7'h2C;
                6'o21: a = upper ? 7'h3F : 7'h2F;
                6'o57: a = upper ? 7'h5B : 7'h28;
                6'o55: a = upper ? 7'h5D : 7'h29;
                6'o73: a = upper ? 7'h2A : 7'h2E;
                6'o54: a = upper ? 7'h2B : 7'h2D;
                6'o40: a = upper ? 7'h5F : 7'h2E;
                default: v = 1'b0;
            endcase
        end
        return {v, a};
    endfunction

endpackage

// File: rtl/fiodec_fifo.sv
// First-word-fall-through FIFO of teletype entries; accepts up to two pushes per cycle.
// The caller guarantees room for the pushes against the count registered at cycle start.
import fiodec_pkg::*;

module fiodec_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               i_push_n,
    input  entry_t                   i_data0,
    input  entry_t                   i_data1,
    input  logic                     i_pop,
    output entry_t                   o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [AW:0]     r_count;
    logic            w_pop;

    assign w_pop   = i_pop & ~o_empty;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

    // NOTE: storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (i_push_n != 2'd0) r_mem[r_wr] <= i_data0;
        if (i_push_n == 2'd2) r_mem[AW'(r_wr + 1'b1)] <= i_data1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= AW'(r_wr + AW'(i_push_n));
            if (w_pop) r_rd <= AW'(r_rd + 1'b1);
            r_count <= (AW+1)'(r_count + (AW+1)'(i_push_n) - (AW+1)'(w_pop));
        end
    end

endmodule

// File: rtl/typewriter_out.sv
// Typewriter output path: edge-detects CPU strobes, decodes FIO-DEC codes with shift
// and cursor tracking, and queues character/scroll entries for the teletype renderer.
import fiodec_pkg::*;

module typewriter_out #(
    parameter int COLS  = 64,
    parameter int ROWS  = 32,
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tyo_strobe,
    input  logic [5:0] tyo_char,
    output logic       tyo_done,
    output logic       term_valid,
    input  logic       term_ready,
    output logic [6:0] term_char,
    output logic [5:0] term_x,
    output logic [4:0] term_y,
    output logic       term_scroll,
    output logic       upper_case
);
    logic                   r_strobe_q;
    logic                   r_pending;
    logic [5:0]             r_code;
    logic                   r_done;
    logic                   r_upper;
    logic [5:0]             r_cx;
    logic [4:0]             r_cy;

    logic [5:0]             w_nx_cx;
    logic [4:0]             w_nx_cy;
    logic                   w_nx_upper;
    logic                   w_char_ent;
    logic [6:0]             w_ch;
    logic                   w_newline;
    logic                   w_scroll;
    logic [6:0]             w_tab;
    logic [7:0]             w_conv;
    logic [1:0]             w_n_ent;
    entry_t                 w_ent0;
    entry_t                 w_ent1;
    logic                   w_fits;
    logic                   w_commit;
    logic                   w_edge;
    entry_t                 w_head;
    logic                   w_empty;
    logic                   w_full;
    logic [$clog2(DEPTH):0] w_count;

    assign w_edge = tyo_strobe & ~r_strobe_q;
    assign w_conv = fiodec_to_ascii(r_code, r_upper);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_nx_cx    = r_cx;
        w_nx_cy    = r_cy;
        w_nx_upper = r_upper;
        w_char_ent = 1'b0;
        w_ch       = '0;
        w_newline  = 1'b0;
        w_scroll   = 1'b0;
        w_tab      = {1'b0, r_cx | 6'd7} + 7'd1;
        case (r_code)
            FD_LOWER: w_nx_upper = 1'b0;
            FD_UPPER: w_nx_upper = 1'b1;
            FD_CR: begin
                w_nx_cx   = '0;
                w_newline = 1'b1;
            end
            FD_BS: if (r_cx != '0) w_nx_cx = r_cx - 6'd1;
            FD_TAB: begin
                if (w_tab >= 7'(COLS)) begin
                    w_nx_cx   = '0;
                    w_newline = 1'b1;
                end else begin
                    w_nx_cx = w_tab[5:0];
                end
            end
            FD_OVERSTRIKE: begin
                w_char_ent = 1'b1;
                w_ch       = 7'h7C;
            end
            default: begin
                if (w_conv[7]) begin
                    w_char_ent = 1'b1;
                    w_ch       = w_conv[6:0];
                    if (r_cx == 6'(COLS-1)) begin
                        w_nx_cx   = '0;
                        w_newline = 1'b1;
                    end else begin
                        w_nx_cx = r_cx + 6'd1;
                    end
                end
            end
        endcase
        // At the bottom row the cursor stays put and the renderer scrolls instead.
        if (w_newline) begin
            if (r_cy < 5'(ROWS-1)) w_nx_cy = r_cy + 5'd1;
            else                   w_scroll = 1'b1;
        end
    end

    assign w_n_ent  = {1'b0, w_char_ent} + {1'b0, w_scroll};
    assign w_ent1   = '{scroll: 1'b1, ch: '0, x: '0, y: '0};
    assign w_ent0   = w_char_ent ? '{scroll: 1'b0, ch: w_ch, x: r_cx, y: r_cy} : w_ent1;
    assign w_fits   = (w_n_ent == 2'd0) ||
                      (!w_full && (int'(w_count) + int'(w_n_ent) <= DEPTH));
    assign w_commit = r_pending & w_fits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_strobe_q <= 1'b0;
            r_pending  <= 1'b0;
            r_code     <= '0;
            r_done     <= 1'b0;
            r_upper    <= 1'b0;
            r_cx       <= '0;
            r_cy       <= '0;
        end else begin
            r_strobe_q <= tyo_strobe;
            r_done     <= w_commit;
            if (w_commit) begin
                r_pending <= 1'b0;
                r_cx      <= w_nx_cx;
                r_cy      <= w_nx_cy;
                r_upper   <= w_nx_upper;
            end else if (w_edge && !r_pending) begin
                r_pending <= 1'b1;
                r_code    <= tyo_char;
            end
        end
    end

    fiodec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push_n (w_commit ? w_n_ent : 2'd0),
        .i_data0  (w_ent0),
        .i_data1  (w_ent1),
        .i_pop    (term_ready),
        .o_head   (w_head),
        .o_empty  (w_empty),
        .o_full   (w_full),
        .o_count  (w_count)
    );

    assign tyo_done    = r_done;
    assign upper_case  = r_upper;
    assign term_valid  = ~w_empty;
    assign term_char   = w_empty ? '0 : w_head.ch;
    assign term_x      = w_empty ? '0 : w_head.x;
    assign term_y      = w_empty ? '0 : w_head.y;
    assign term_scroll = w_empty ? 1'b0 : w_head.scroll;

endmodule
